// File: rtl/framed_serial_argmax.sv
// Streaming argmax over valid/last framed serial samples; publishes {argmax, max_value}
// with a one-cycle out_valid pulse after the last beat of each frame.
module framed_serial_argmax #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned ARGMAX_WIDTH = 5,
    parameter int unsigned SIGNED       = 1,
    parameter int unsigned TIE_LAST     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [WIDTH-1:0]        in,
    output logic                    out_valid,
    output logic [ARGMAX_WIDTH-1:0] argmax,
    output logic [WIDTH-1:0]        max_value,
    output logic                    overflow,
    output logic                    busy
);

    typedef enum logic [0:0] {StFirst, StAcc} state_e;

    localparam logic [ARGMAX_WIDTH-1:0] IdxMax = '1;

    state_e                  state_q, state_d;
    logic [ARGMAX_WIDTH-1:0] idx_q, idx_d;
    logic                    full_q, full_d;
    logic [WIDTH-1:0]        best_val_q, best_val_d;
    logic [ARGMAX_WIDTH-1:0] best_idx_q, best_idx_d;
    logic                    ovf_q, ovf_d;
    logic                    out_valid_d;
    logic [ARGMAX_WIDTH-1:0] argmax_d;
    logic [WIDTH-1:0]        max_value_d;
    logic                    overflow_d;
    logic                    gt, win;

    always_comb begin
        if (SIGNED != 0) begin
            gt = $signed(in) > $signed(best_val_q);
        end else begin
            gt = in > best_val_q;
        end
        win = gt || ((TIE_LAST != 0) && (in == best_val_q));
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        full_d      = full_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        argmax_d    = argmax;
        max_value_d = max_value;
        overflow_d  = overflow;

        if (clr) begin
            // Abort discards the partial frame; published outputs are left alone.
            state_d = StFirst;
            idx_d   = '0;
            full_d  = 1'b0;
        end else if (in_valid) begin
            unique case (state_q)
                StFirst: begin
                    best_val_d = in;
                    best_idx_d = '0;
                    idx_d      = ARGMAX_WIDTH'(1);
                    full_d     = 1'b0;
                    ovf_d      = 1'b0;
                    state_d    = in_last ? StFirst : StAcc;
                end
                StAcc: begin
                    if (win) begin
                        best_val_d = in;
                        best_idx_d = idx_q;
                    end
                    // full_q marks that beat IdxMax was already taken; any further beat overflows.
                    if (full_q) begin
                        ovf_d = 1'b1;
                    end
                    if (idx_q == IdxMax) begin
                        full_d = 1'b1;
                    end else begin
                        idx_d = idx_q + ARGMAX_WIDTH'(1);
                    end
                    if (in_last) begin
                        state_d = StFirst;
                    end
                end
                default: state_d = StFirst;
            endcase

            if (in_last) begin
                out_valid_d = 1'b1;
                argmax_d    = best_idx_d;
                max_value_d = best_val_d;
                overflow_d  = ovf_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StFirst;
            idx_q      <= '0;
            full_q     <= 1'b0;
            best_val_q <= '0;
            best_idx_q <= '0;
            ovf_q      <= 1'b0;
            out_valid  <= 1'b0;
            argmax     <= '0;
            max_value  <= '0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            full_q     <= full_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            ovf_q      <= ovf_d;
            out_valid  <= out_valid_d;
            argmax     <= argmax_d;
            max_value  <= max_value_d;
            overflow   <= overflow_d;
        end
    end

    assign busy = (state_q == StAcc);

endmodule

// File: tb/tb_framed_serial_argmax.sv
// Bench for framed_serial_argmax: four variants (SIGNED x TIE_LAST) share one stimulus stream
// and are checked every cycle against a frame-queue reference model.
module tb_framed_serial_argmax;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic       in_last;
    logic [3:0] din;

    logic       ov [4];
    logic [4:0] am [4];
    logic [3:0] mv [4];
    logic       of [4];
    logic       bz [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        framed_serial_argmax #(
            .WIDTH       (4),
            .ARGMAX_WIDTH(5),
            .SIGNED      (g % 2),
            .TIE_LAST    (g / 2)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .in_valid (in_valid),
            .in_last  (in_last),
            .in       (din),
            .out_valid(ov[g]),
            .argmax   (am[g]),
            .max_value(mv[g]),
            .overflow (of[g]),
            .busy     (bz[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: samples of the open frame plus the last published result per variant.
    logic [3:0] frame[$];
    logic       exp_ov;
    logic [4:0] exp_am [4];
    logic [3:0] exp_mv [4];
    logic       exp_of [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sval(input logic [3:0] v, input bit sgn);
        if (sgn) return int'($signed(v));
        return int'({28'b0, v});
    endfunction

    task automatic publish();
        for (int k = 0; k < 4; k++) begin
            int best;
            best = 0;
            for (int i = 1; i < frame.size(); i++) begin
                int a, b;
                a = sval(frame[i], k[0]);
                b = sval(frame[best], k[0]);
                if (a > b || (k[1] && a == b)) best = i;
            end
            exp_am[k] = (best > 31) ? 5'd31 : 5'(best);
            exp_mv[k] = frame[best];
            exp_of[k] = frame.size() > 32;
        end
        exp_ov = 1'b1;
    endtask

    task automatic model_reset();
        frame.delete();
        exp_ov = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_am[k] = '0;
            exp_mv[k] = '0;
            exp_of[k] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("out_valid%0d", k), 32'(ov[k]), 32'(exp_ov));
            check($sformatf("argmax%0d", k), 32'(am[k]), 32'(exp_am[k]));
            check($sformatf("max_value%0d", k), 32'(mv[k]), 32'(exp_mv[k]));
            check($sformatf("overflow%0d", k), 32'(of[k]), 32'(exp_of[k]));
            check($sformatf("busy%0d", k), 32'(bz[k]), 32'(frame.size() > 0));
        end
    endtask

    // One clock: drive inputs, step the model after the edge, compare all variants.
    task automatic cyc(input logic v, input logic l, input logic c, input logic [3:0] d);
        in_valid = v;
        in_last  = l;
        clr      = c;
        din      = d;
        @(posedge clk);
        #1;
        exp_ov = 1'b0;
        if (c) begin
            frame.delete();
        end else if (v) begin
            frame.push_back(d);
            if (l) begin
                publish();
                frame.delete();
            end
        end
        check_all();
    endtask

    task automatic send(input logic [3:0] vals[$]);
        for (int i = 0; i < vals.size(); i++) cyc(1'b1, i == vals.size() - 1, 1'b0, vals[i]);
    endtask

    initial begin
        logic [3:0] q[$];
        rst      = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        din      = '0;
        model_reset();
        #12;
        check_all();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'h0);

        // Ascending -8..7.
        q.delete();
        for (int i = -8; i < 8; i++) q.push_back(4'(i));
        send(q);
        cyc(1'b0, 1'b0, 1'b0, 4'h0);

        // Ties and signed vs unsigned.
        q = '{4'd3, 4'd5, 4'd1, 4'd5};
        send(q);
        q = '{4'h7, 4'hF};
        send(q);

        // Single-beat frame followed back-to-back by a gapped frame.
        cyc(1'b1, 1'b1, 1'b0, 4'hD);
        cyc(1'b1, 1'b0, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 1'b0, 4'h9);
        cyc(1'b0, 1'b0, 1'b0, 4'h9);
        cyc(1'b1, 1'b1, 1'b0, 4'h2);

        // 33-beat frame with max on the last beat, then exactly 32 beats.
        q.delete();
        for (int i = 0; i < 32; i++) q.push_back(4'h0);
        q.push_back(4'h7);
        send(q);
        q.delete();
        for (int i = 0; i < 31; i++) q.push_back(4'h1);
        q.push_back(4'h5);
        send(q);

        // Abort mid-frame (clr with a same-cycle last beat), then a clean frame.
        cyc(1'b1, 1'b0, 1'b0, 4'h3);
        cyc(1'b1, 1'b1, 1'b1, 4'h7);
        q = '{4'd1, 4'd6};
        send(q);

        // Asynchronous reset mid-frame, away from the clock edge.
        cyc(1'b1, 1'b0, 1'b0, 4'h4);
        cyc(1'b1, 1'b0, 1'b0, 4'h6);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'h0);

        // Random frames with gaps, stray in_last and occasional aborts.
        for (int f = 0; f < 200; f++) begin
            int len;
            len = $urandom_range(1, 40);
            for (int b = 0; b < len; b++) begin
                while ($urandom_range(0, 3) == 0) cyc(1'b0, 1'($urandom), 1'b0, 4'($urandom));
                cyc(1'b1, b == len - 1, $urandom_range(0, 80) == 0, 4'($urandom));
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
